// File: rtl/convert_fixed_to_float_seq_if.sv
// Handshake/data bundle for convert_fixed_to_float_seq.
//   i_start : request to convert i_fixed (driven by master)
//   i_fixed : signed 32-bit fixed-point operand (driven by master)
//   o_busy  : conversion in progress (driven by slave)
//   o_ready : one-cycle pulse, o_float valid from this cycle on (driven by slave)
//   o_float : IEEE-754 single-precision result (driven by slave)
interface convert_fixed_to_float_seq_if;
    logic        i_start;
    logic [31:0] i_fixed;
    logic        o_busy;
    logic        o_ready;
    logic [31:0] o_float;

    modport master (
        output i_start,
        output i_fixed,
        input  o_busy,
        input  o_ready,
        input  o_float
    );

    modport slave (
        input  i_start,
        input  i_fixed,
        output o_busy,
        output o_ready,
        output o_float
    );
endinterface

// File: rtl/convert_fixed_to_float_seq.sv
// Sequential signed fixed-point (Q(31-FRAC).FRAC) to IEEE-754 single-precision converter.
// The magnitude is normalised one bit per cycle, so latency is 2 + (leading zeros of |x|).
// Ports:
//   i_clk : clock, all state updates on rising edge
//   i_rst : synchronous active-high reset, aborts any conversion
//   bus   : slave side of convert_fixed_to_float_seq_if (start/fixed in, busy/ready/float out)
// Parameters:
//   FRAC  : number of fractional bits of the input (default 26, Q5.26)
// Build option:
//   ROUND_NEAREST_EN : when defined, mantissa is rounded to nearest-even; otherwise truncated.
module convert_fixed_to_float_seq #(
    parameter int unsigned FRAC = 26
) (
    input logic                        i_clk,
    input logic                        i_rst,
    convert_fixed_to_float_seq_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StNorm, StPack} state_e;

    // Exponent when the MSB of the magnitude sits at bit 31 (K = 0).
    localparam logic [7:0] ExpBase = 8'(127 + 31 - FRAC);

    state_e      r_state;
    logic        r_sign;
    logic [31:0] r_mag;
    logic [5:0]  r_k;
    logic        r_busy;
    logic        r_ready;
    logic [31:0] r_float;

    logic [31:0] w_fixed_abs;
    logic [7:0]  w_exp_trunc;
    logic [22:0] w_mant_trunc;
    logic [7:0]  w_exp;
    logic [22:0] w_mant;
    logic [31:0] w_packed;
    logic        w_norm_done;

    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    assign w_fixed_abs  = bus.i_fixed[31] ? (~bus.i_fixed + 32'd1) : bus.i_fixed;
    assign w_norm_done  = r_mag[31] || (r_mag == 32'd0);
    assign w_exp_trunc  = ExpBase - {2'b00, r_k};
    assign w_mant_trunc = r_mag[30:8];

`ifdef ROUND_NEAREST_EN
    logic        w_guard;
    logic        w_sticky;
    logic        w_round_up;
    logic [23:0] w_mant_sum;

    assign w_guard    = r_mag[7];
    assign w_sticky   = |r_mag[6:0];
    // Ties (guard set, sticky clear) round toward an even mantissa.
    assign w_round_up = w_guard && (w_sticky || r_mag[8]);
    assign w_mant_sum = {1'b0, w_mant_trunc} + {23'd0, w_round_up};
    // Carry out of the mantissa bumps the exponent; remaining fraction bits are zero.
    assign w_mant     = w_mant_sum[23] ? 23'd0 : w_mant_sum[22:0];
    assign w_exp      = w_exp_trunc + {7'd0, w_mant_sum[23]};
`else
    logic w_unused_low_bits;

    assign w_unused_low_bits = ^r_mag[7:0];
    assign w_mant            = w_mant_trunc;
    assign w_exp             = w_exp_trunc;
`endif

    // Zero input packs to +0 regardless of the captured sign.
    assign w_packed = (r_mag == 32'd0) ? 32'd0 : {r_sign, w_exp, w_mant};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_sign  <= 1'b0;
            r_mag   <= 32'd0;
            r_k     <= 6'd0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
            r_float <= 32'd0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (bus.i_start) begin
                        r_sign  <= bus.i_fixed[31];
                        r_mag   <= w_fixed_abs;
                        r_k     <= 6'd0;
                        r_busy  <= 1'b1;
                        r_state <= StNorm;
                    end
                end
                StNorm: begin
                    if (!w_norm_done) begin
                        r_mag <= {r_mag[30:0], 1'b0};
                        r_k   <= r_k + 6'd1;
                    end else begin
                        r_state <= StPack;
                    end
                end
                StPack: begin
                    r_float <= w_packed;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.o_busy  = r_busy;
    assign bus.o_ready = r_ready;
    assign bus.o_float = r_float;

endmodule

// File: tb/tb_convert_fixed_to_float_seq.sv
// Directed testbench for convert_fixed_to_float_seq (default FRAC = 26).
module tb_convert_fixed_to_float_seq;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    convert_fixed_to_float_seq_if bus_if ();

    convert_fixed_to_float_seq #(
        .FRAC (26)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ROUND_NEAREST_EN
    localparam logic [31:0] ExpRound = 32'h4000_0000;
`else
    localparam logic [31:0] ExpRound = 32'h3FFF_FFFF;
`endif

    // Present a START with operand v for one edge, then scramble FIXED.
    task automatic start_conv(input logic [31:0] v);
        @(negedge clk);
        bus_if.i_start = 1'b1;
        bus_if.i_fixed = v;
        @(posedge clk);
        #1;
        bus_if.i_start = 1'b0;
        bus_if.i_fixed = 32'hDEAD_BEEF;
    endtask

    // Count edges until READY is seen (bounded); also count cycles BUSY was high.
    task automatic wait_ready(output int lat, output int busy_cycles);
        lat         = 0;
        busy_cycles = bus_if.o_busy ? 1 : 0;
        while (lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus_if.o_ready) break;
            if (bus_if.o_busy) busy_cycles++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (bus_if.o_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy got %b want 0", bus_if.o_busy);
        end
        n_tests++;
        if (bus_if.o_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready got %b want 0", bus_if.o_ready);
        end
        n_tests++;
        if (bus_if.o_float !== 32'h0) begin
            n_fail++; $display("FAIL reset_float got %h want 00000000", bus_if.o_float);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_one;
        int lat, bc;
        start_conv(32'h0400_0000);
        wait_ready(lat, bc);
        n_tests++;
        if (lat !== 7) begin n_fail++; $display("FAIL one_latency got %0d want 7", lat); end
        n_tests++;
        if (bus_if.o_float !== 32'h3F80_0000) begin
            n_fail++; $display("FAIL one_float got %h want 3f800000", bus_if.o_float);
        end
        n_tests++;
        if (bc !== 7) begin n_fail++; $display("FAIL one_busy_cycles got %0d want 7", bc); end
        n_tests++;
        if (bus_if.o_busy !== 1'b0) begin
            n_fail++; $display("FAIL one_busy_at_ready got %b want 0", bus_if.o_busy);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (bus_if.o_ready !== 1'b0) begin
            n_fail++; $display("FAIL one_ready_pulse got %b want 0", bus_if.o_ready);
        end
    endtask

    task automatic test_negative;
        int lat, bc;
        start_conv(32'hFC00_0000);
        wait_ready(lat, bc);
        n_tests++;
        if (bus_if.o_float !== 32'hBF80_0000) begin
            n_fail++; $display("FAIL neg1_float got %h want bf800000", bus_if.o_float);
        end
        n_tests++;
        if (lat !== 7) begin n_fail++; $display("FAIL neg1_latency got %0d want 7", lat); end
        start_conv(32'h8000_0000);
        wait_ready(lat, bc);
        n_tests++;
        if (bus_if.o_float !== 32'hC200_0000) begin
            n_fail++; $display("FAIL min_float got %h want c2000000", bus_if.o_float);
        end
        n_tests++;
        if (lat !== 2) begin n_fail++; $display("FAIL min_latency got %0d want 2", lat); end
    endtask

    task automatic test_zero_and_tiny;
        int lat, bc;
        start_conv(32'h0000_0000);
        wait_ready(lat, bc);
        n_tests++;
        if (bus_if.o_float !== 32'h0) begin
            n_fail++; $display("FAIL zero_float got %h want 00000000", bus_if.o_float);
        end
        n_tests++;
        if (lat !== 2) begin n_fail++; $display("FAIL zero_latency got %0d want 2", lat); end
        start_conv(32'h0000_0001);
        wait_ready(lat, bc);
        n_tests++;
        if (bus_if.o_float !== 32'h3280_0000) begin
            n_fail++; $display("FAIL tiny_float got %h want 32800000", bus_if.o_float);
        end
        n_tests++;
        if (lat !== 33) begin n_fail++; $display("FAIL tiny_latency got %0d want 33", lat); end
    endtask

    task automatic test_round;
        int lat, bc;
        start_conv(32'h07FF_FFFF);
        wait_ready(lat, bc);
        n_tests++;
        if (bus_if.o_float !== ExpRound) begin
            n_fail++; $display("FAIL round_float got %h want %h", bus_if.o_float, ExpRound);
        end
        n_tests++;
        if (lat !== 7) begin n_fail++; $display("FAIL round_latency got %0d want 7", lat); end
    endtask

    task automatic test_ignore_start;
        int lat, bc, extra;
        start_conv(32'h0400_0000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus_if.i_start = 1'b1;
        bus_if.i_fixed = 32'h0800_0000;
        @(posedge clk);
        #1;
        bus_if.i_start = 1'b0;
        n_tests++;
        if (bus_if.o_float !== ExpRound) begin
            n_fail++; $display("FAIL ignore_float_held got %h want %h", bus_if.o_float, ExpRound);
        end
        wait_ready(lat, bc);
        n_tests++;
        if (lat !== 3) begin n_fail++; $display("FAIL ignore_latency got %0d want 3", lat); end
        n_tests++;
        if (bus_if.o_float !== 32'h3F80_0000) begin
            n_fail++; $display("FAIL ignore_float got %h want 3f800000", bus_if.o_float);
        end
        extra = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus_if.o_ready) extra++;
        end
        n_tests++;
        if (extra !== 0) begin n_fail++; $display("FAIL ignore_extra_ready got %0d want 0", extra); end
    endtask

    task automatic test_abort;
        int lat, bc, extra;
        start_conv(32'h0400_0000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_tests++;
        if (bus_if.o_busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_busy got %b want 0", bus_if.o_busy);
        end
        n_tests++;
        if (bus_if.o_float !== 32'h0) begin
            n_fail++; $display("FAIL abort_float got %h want 00000000", bus_if.o_float);
        end
        extra = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus_if.o_ready) extra++;
        end
        n_tests++;
        if (extra !== 0) begin n_fail++; $display("FAIL abort_ready got %0d want 0", extra); end
        start_conv(32'hFC00_0000);
        wait_ready(lat, bc);
        n_tests++;
        if (bus_if.o_float !== 32'hBF80_0000) begin
            n_fail++; $display("FAIL abort_next_float got %h want bf800000", bus_if.o_float);
        end
        n_tests++;
        if (lat !== 7) begin n_fail++; $display("FAIL abort_next_latency got %0d want 7", lat); end
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        start_conv(32'h8000_0000);
        wait_ready(lat, bc);
        n_tests++;
        if (lat !== 2) begin n_fail++; $display("FAIL b2b_first_latency got %0d want 2", lat); end
        // START presented in the READY cycle must be accepted on the next edge.
        start_conv(32'h0400_0000);
        n_tests++;
        if (bus_if.o_busy !== 1'b1 || bus_if.o_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept busy/ready got %b/%b want 1/0", bus_if.o_busy, bus_if.o_ready);
        end
        n_tests++;
        if (bus_if.o_float !== 32'hC200_0000) begin
            n_fail++; $display("FAIL b2b_float_held got %h want c2000000", bus_if.o_float);
        end
        wait_ready(lat, bc);
        n_tests++;
        if (lat !== 7) begin n_fail++; $display("FAIL b2b_second_latency got %0d want 7", lat); end
        n_tests++;
        if (bus_if.o_float !== 32'h3F80_0000) begin
            n_fail++; $display("FAIL b2b_second_float got %h want 3f800000", bus_if.o_float);
        end
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        rst            = 1'b1;
        bus_if.i_start = 1'b0;
        bus_if.i_fixed = 32'h0;
        test_reset();
        test_one();
        test_negative();
        test_zero_and_tiny();
        test_round();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
